ov7670_cfg_seq: RTL and testbench

//  Power-up and register-configuration sequencer for the OV7670 camera. Drives camera RESET/PWDN

---
 rtl/ov7670_pkg.sv | 33 +++
 rtl/ov7670_reg_rom.sv | 54 +++++
 rtl/ov7670_cfg_seq.sv | 134 +++++++++++++
 tb/tb_ov7670_cfg_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared state encoding and constants for the OV7670 configuration sequencer
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_RST,
    ST_LOAD,
    ST_WRITE,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

  localparam logic [7:0] SCCB_DEV_ID = 8'h42;
  localparam logic [7:0] SWRST_REG   = 8'h12;

  localparam int         DEF_PWR_DLY_CYC = 150_000;
  localparam int         DEF_RST_DLY_CYC = 150_000;
  localparam int         DEF_GAP_CYC     = 500;
  localparam int         DEF_SWRST_CYC   = 50_000;
  localparam int         DEF_TMO_CYC     = 20_000;
  localparam logic [7:0] DEF_REG_NUM     = 8'd166;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // COM7 with bit7 set resets every sensor register; the sensor needs time to recover.
  function automatic logic is_swrst(input logic [7:0] addr, input logic [7:0] data);
    return (addr == SWRST_REG) && data[7];
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// rtl/ov7670_reg_rom.sv - registered OV7670 register table, {addr,data} per entry
module ov7670_reg_rom
  import ov7670_pkg::*;
(
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  idx,
  output logic [15:0] q
);

  // Entries past the populated table read as FF/FF, an inert write to an unused register.
  function automatic logic [15:0] rom_entry(input logic [7:0] i);
    case (i)
      8'd0:  rom_entry = 16'h1280;  8'd1:  rom_entry = 16'h1101;
      8'd2:  rom_entry = 16'h3a04;  8'd3:  rom_entry = 16'h1204;
      8'd4:  rom_entry = 16'h8c00;  8'd5:  rom_entry = 16'h40d0;
      8'd6:  rom_entry = 16'h1716;  8'd7:  rom_entry = 16'h1804;
      8'd8:  rom_entry = 16'h3224;  8'd9:  rom_entry = 16'h1902;
      8'd10: rom_entry = 16'h1a7a;  8'd11: rom_entry = 16'h030a;
      8'd12: rom_entry = 16'h0c04;  8'd13: rom_entry = 16'h3e19;
      8'd14: rom_entry = 16'h703a;  8'd15: rom_entry = 16'h7135;
      8'd16: rom_entry = 16'h7211;  8'd17: rom_entry = 16'h73f1;
      8'd18: rom_entry = 16'ha202;  8'd19: rom_entry = 16'h7a20;
      8'd20: rom_entry = 16'h7b10;  8'd21: rom_entry = 16'h7c1e;
      8'd22: rom_entry = 16'h7d35;  8'd23: rom_entry = 16'h7e5a;
      8'd24: rom_entry = 16'h7f69;  8'd25: rom_entry = 16'h8076;
      8'd26: rom_entry = 16'h8180;  8'd27: rom_entry = 16'h8288;
      8'd28: rom_entry = 16'h838f;  8'd29: rom_entry = 16'h8496;
      8'd30: rom_entry = 16'h85a3;  8'd31: rom_entry = 16'h86af;
      8'd32: rom_entry = 16'h87c4;  8'd33: rom_entry = 16'h88d7;
      8'd34: rom_entry = 16'h89e8;  8'd35: rom_entry = 16'h13e0;
      8'd36: rom_entry = 16'h0000;  8'd37: rom_entry = 16'h1000;
      8'd38: rom_entry = 16'h0d40;  8'd39: rom_entry = 16'h1418;
      8'd40: rom_entry = 16'ha505;  8'd41: rom_entry = 16'hab07;
      8'd42: rom_entry = 16'h2495;  8'd43: rom_entry = 16'h2533;
      8'd44: rom_entry = 16'h26e3;  8'd45: rom_entry = 16'h9f78;
      8'd46: rom_entry = 16'ha068;  8'd47: rom_entry = 16'ha103;
      8'd48: rom_entry = 16'ha6d8;  8'd49: rom_entry = 16'ha7d8;
      8'd50: rom_entry = 16'ha8f0;  8'd51: rom_entry = 16'ha990;
      8'd52: rom_entry = 16'haa94;  8'd53: rom_entry = 16'h13e5;
      default: rom_entry = 16'hffff;
    endcase
  endfunction

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= rom_entry(idx);
    end
  end

endmodule

// File: rtl/ov7670_cfg_seq.sv
// rtl/ov7670_cfg_seq.sv - OV7670 power-up timing and register-table write sequencer
module ov7670_cfg_seq
  import ov7670_pkg::*;
#(
  parameter int         PWR_DLY_CYC = DEF_PWR_DLY_CYC,
  parameter int         RST_DLY_CYC = DEF_RST_DLY_CYC,
  parameter int         GAP_CYC     = DEF_GAP_CYC,
  parameter int         SWRST_CYC   = DEF_SWRST_CYC,
  parameter int         TMO_CYC     = DEF_TMO_CYC,
  parameter logic [7:0] REG_NUM     = DEF_REG_NUM
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       wr_done,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cam_rst_n,
  output logic       cam_pwdn,
  output logic [7:0] reg_idx,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err
);

  localparam int MAX_CYC = max_int(max_int(max_int(PWR_DLY_CYC, RST_DLY_CYC),
                                           max_int(GAP_CYC, SWRST_CYC)), TMO_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] SWRST_LAST = CNT_W'(SWRST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_CYC - 1);

  cfg_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       idx_nxt;
  logic [15:0]      rom_q;
  logic [CNT_W-1:0] gap_last;

  ov7670_reg_rom u_rom (
    .sclk  (sclk),
    .rst_n (rst_n),
    .en    (state == ST_LOAD),
    .idx   (reg_idx),
    .q     (rom_q)
  );

  // The ROM output register only loads in LOAD, so it doubles as the held write payload.
  assign wr_addr  = rom_q[15:8];
  assign wr_data  = rom_q[7:0];
  assign gap_last = is_swrst(wr_addr, wr_data) ? SWRST_LAST : GAP_LAST;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_PWR;
      cnt      <= '0;
      reg_idx  <= '0;
      cam_pwdn <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      reg_idx  <= idx_nxt;
      cam_pwdn <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = reg_idx;
    case (state)
      ST_PWR: begin
        if (cnt == PWR_LAST) begin
          state_nxt = ST_RST;
          cnt_nxt   = '0;
        end
      end
      ST_RST: begin
        if (cnt == RST_LAST) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_WRITE;
        cnt_nxt   = '0;
      end
      ST_WRITE: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (wr_done) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else if (cnt == TMO_LAST) begin
          state_nxt = ST_ERROR;
          cnt_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (cnt == gap_last) begin
          cnt_nxt = '0;
          if (reg_idx == REG_NUM - 8'd1) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_LOAD;
            idx_nxt   = reg_idx + 8'd1;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        cnt_nxt = cnt;
        if (start) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_PWR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign wr_en     = (state == ST_WRITE);
  assign cam_rst_n = (state != ST_PWR);
  assign cfg_done  = (state == ST_DONE);
  assign cfg_err   = (state == ST_ERROR);
  assign cfg_busy  = !(cfg_done || cfg_err);

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// tb/tb_ov7670_cfg_seq.sv - self-checking bench for ov7670_cfg_seq with a small timing model
module tb_ov7670_cfg_seq;

  localparam int P = 10;
  localparam int R = 8;
  localparam int G = 4;
  localparam int S = 20;
  localparam int T = 50;
  localparam int NV = 11;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       wr_done = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       cam_rst_n;
  logic       cam_pwdn;
  logic [7:0] reg_idx;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_err;

  int   checks = 0;
  int   failures = 0;
  int   cyc;
  int   n_rise;
  logic wr_en_q;

  typedef struct {
    bit restart;
    int lat;
    int idx;
  } vec_t;

  vec_t        vecs [NV];
  logic [15:0] rom_model [3];

  ov7670_cfg_seq #(
    .PWR_DLY_CYC (P),
    .RST_DLY_CYC (R),
    .GAP_CYC     (G),
    .SWRST_CYC   (S),
    .TMO_CYC     (T),
    .REG_NUM     (8'd3)
  ) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .start     (start),
    .wr_done   (wr_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cam_rst_n (cam_rst_n),
    .cam_pwdn  (cam_pwdn),
    .reg_idx   (reg_idx),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      n_rise  <= 0;
    end else begin
      wr_en_q <= wr_en;
      if (wr_en && !wr_en_q) n_rise <= n_rise + 1;
    end
  end

  // Idle cycles after a write: the soft-reset write needs the long recovery.
  function automatic int gap_of(input logic [15:0] e);
    return (e[15:8] == 8'h12 && e[7]) ? S : G;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_rise(input int bound, output int c);
    int n = 0;
    while (!wr_en && n < bound) begin
      @(negedge sclk);
      n++;
    end
    chk("wait_wr_en", wr_en, 1);
    c = cyc;
  endtask

  task automatic pulse_start(output int c);
    c = cyc;
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
  endtask

  task automatic answer(input int lat);
    for (int j = 1; j < lat; j++) @(negedge sclk);
    wr_done = 1'b1;
    @(negedge sclk);
    wr_done = 1'b0;
  endtask

  initial begin
    int          c, s, lat, g, exp_s, n;
    logic [15:0] e;

    rom_model[0] = 16'h1280;
    rom_model[1] = 16'h1101;
    rom_model[2] = 16'h3a04;
    vecs[0]  = '{1'b0, 30, 0};
    vecs[1]  = '{1'b0, 30, 1};
    vecs[2]  = '{1'b0, 30, 2};
    vecs[3]  = '{1'b1, int'($urandom_range(49, 1)), 0};
    vecs[4]  = '{1'b0, int'($urandom_range(49, 1)), 1};
    vecs[5]  = '{1'b0, T, 2};
    vecs[6]  = '{1'b1, int'($urandom_range(49, 1)), 0};
    vecs[7]  = '{1'b0, 0, 1};
    vecs[8]  = '{1'b1, int'($urandom_range(49, 1)), 0};
    vecs[9]  = '{1'b0, 1, 1};
    vecs[10] = '{1'b0, int'($urandom_range(49, 1)), 2};

    repeat (3) @(negedge sclk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cam_rst_n", cam_rst_n, 0);
    chk("rst_cam_pwdn", cam_pwdn, 1);
    chk("rst_reg_idx", reg_idx, 0);
    chk("rst_flags", {cfg_busy, cfg_done, cfg_err}, 3'b100);

    rst_n = 1'b1;
    @(negedge sclk);
    chk("pwdn_released", cam_pwdn, 0);
    chk("cam_rst_n_held", cam_rst_n, 0);
    n = 0;
    while (!cam_rst_n && n < 50) begin
      @(negedge sclk);
      n++;
    end
    chk("cam_rst_n_rise_cyc", cyc, P);

    exp_s = P + R + 1;
    for (int vi = 0; vi < NV; vi++) begin
      e   = rom_model[vecs[vi].idx];
      lat = vecs[vi].lat;
      if (vecs[vi].restart) begin
        pulse_start(c);
        chk("restart_flags_clear", {cfg_done, cfg_err}, 2'b00);
        chk("restart_busy", cfg_busy, 1);
        chk("restart_cam_rst_n", cam_rst_n, 1);
        exp_s = c + 2;
      end
      wait_rise(300, s);
      chk("wr_start_cyc", s, exp_s);
      chk("wr_addr", wr_addr, e[15:8]);
      chk("wr_data", wr_data, e[7:0]);
      chk("wr_reg_idx", reg_idx, vecs[vi].idx);
      if (lat == 0) begin
        repeat (T - 1) @(negedge sclk);
        chk("wr_en_before_tmo", wr_en, 1);
        @(negedge sclk);
        chk("wr_en_after_tmo", wr_en, 0);
        chk("tmo_flags", {cfg_busy, cfg_done, cfg_err}, 3'b001);
        chk("tmo_reg_idx", reg_idx, vecs[vi].idx);
      end else begin
        for (int j = 1; j < lat; j++) begin
          @(negedge sclk);
          start = (vi == 0 && j == 5);
        end
        start = 1'b0;
        chk("wr_en_held", wr_en, 1);
        chk("wr_addr_stable", wr_addr, e[15:8]);
        chk("idx_stable", reg_idx, vecs[vi].idx);
        wr_done = 1'b1;
        @(negedge sclk);
        wr_done = 1'b0;
        chk("wr_en_fall", wr_en, 0);
        g = gap_of(e);
        if (vi == 0) begin
          @(negedge sclk);
          wr_done = 1'b1;
          @(negedge sclk);
          wr_done = 1'b0;
          chk("gap_spurious_busy", {cfg_busy, wr_en}, 2'b10);
        end
        if (vecs[vi].idx == 2) begin
          while (cyc < s + lat + g - 1) @(negedge sclk);
          chk("pre_done_busy", {cfg_busy, cfg_done}, 2'b10);
          @(negedge sclk);
          chk("done_flags", {cfg_busy, cfg_done, cfg_err}, 3'b010);
          chk("done_reg_idx", reg_idx, 2);
          chk("done_wr_en", wr_en, 0);
        end else begin
          exp_s = s + lat + g + 1;
        end
      end
    end
    chk("write_count", n_rise, NV);

    pulse_start(c);
    wait_rise(10, s);
    chk("final_start_cyc", s, c + 2);
    answer(10);
    wait_rise(50, s);
    chk("final_idx1", reg_idx, 1);
    repeat (3) @(negedge sclk);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_cam_rst_n", cam_rst_n, 0);
    chk("midrst_cam_pwdn", cam_pwdn, 1);
    chk("midrst_reg_idx", reg_idx, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_busy", cfg_busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
